// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian kernel consumer: default geometry, array types,
// accumulator sizing and the convolution FSM state encoding.
package gauss_pkg;

   localparam int unsigned DEF_MAX_KERNEL = 7;
   localparam int unsigned DEF_NORM_SHIFT = 8;

   typedef logic [DEF_MAX_KERNEL-1:0][DEF_MAX_KERNEL-1:0][7:0] kernel_t;
   typedef logic [DEF_MAX_KERNEL-1:0][DEF_MAX_KERNEL-1:0][7:0] window_t;

   // 8x8 product (16 bits) summed over up to MAX_KERNEL^2 taps.
   function automatic int unsigned acc_width(input int unsigned max_kernel);
      return 16 + $clog2(max_kernel * max_kernel);
   endfunction

   localparam int unsigned DEF_ACC_W = acc_width(DEF_MAX_KERNEL);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READY,
      ST_MAC,
      ST_OUT
   } conv_state_t;

endpackage

// File: rtl/gauss_window_conv_tap_index_counter.sv
// Row/column tap walker for the serial MAC; wraps col at a runtime edge value
// and flags the final (wrap, wrap) tap.
module tap_index_counter #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] wrap,
   output logic [W-1:0] row,
   output logic [W-1:0] col,
   output logic         last_tap
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == wrap) begin
            col <= '0;
            row <= row + W'(1);
         end else begin
            col <= col + W'(1);
         end
      end
   end

   always_comb begin
      last_tap = (row == wrap) && (col == wrap);
   end

endmodule

// File: rtl/gauss_window_conv.sv
// Applies a latched Gaussian kernel to pixel windows via a serial MAC and emits one
// rounded, normalised 8-bit pixel per window. Define CONV_SATURATE_EN to clamp at 255.
module gauss_window_conv
   import gauss_pkg::*;
#(
   parameter int unsigned MAX_KERNEL = DEF_MAX_KERNEL,
   parameter int unsigned NORM_SHIFT = DEF_NORM_SHIFT
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] kernel,
   input  logic [$clog2(MAX_KERNEL+1)-1:0]           kernel_size,
   input  logic                                      kernel_load,
   input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] win,
   input  logic                                      win_valid,
   output logic                                      win_ready,
   output logic [7:0]                                pix_out,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic                                      err
);

   localparam int unsigned SZW   = $clog2(MAX_KERNEL + 1);
   localparam int unsigned ACC_W = acc_width(MAX_KERNEL);
   localparam int unsigned SUMW  = ACC_W + 1;
   localparam logic [SZW-1:0]  MAX_SZ = SZW'(MAX_KERNEL);
   localparam logic [SUMW-1:0] ROUND  = SUMW'(1) << (NORM_SHIFT - 1);

   typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] arr_t;

   conv_state_t state_q, state_d;

   arr_t            kern_q;
   logic [SZW-1:0]  size_q;
   arr_t            work_kern_q;
   logic [SZW-1:0]  last_idx_q;
   arr_t            win_q;
   logic [ACC_W-1:0] acc_q;
   logic            err_q;

   logic            size_legal;
   logic            load_window;
   logic            load_ok;
   logic            load_bad;
   logic            accept;
   logic            mac_en;
   logic [SZW-1:0]  row;
   logic [SZW-1:0]  col;
   logic            last_tap;
   logic [15:0]     tap_prod;
   logic [7:0]      pix_res;

   always_comb begin
      size_legal  = kernel_size[0] && (kernel_size != '0) && (kernel_size <= MAX_SZ);
      load_window = (state_q == ST_IDLE) || (state_q == ST_READY);
      load_ok     = kernel_load && load_window && size_legal;
      load_bad    = kernel_load && load_window && !size_legal;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      win_ready = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      mac_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_ok) state_d = ST_READY;
         end
         ST_READY: begin
            win_ready = 1'b1;
            if (win_valid) begin
               accept  = 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (last_tap) state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_READY;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The window snapshots the stored kernel on accept, so a load at the same edge
   // only affects later windows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kern_q      <= '0;
         size_q      <= '0;
         work_kern_q <= '0;
         last_idx_q  <= '0;
         win_q       <= '0;
         acc_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         if (load_ok) begin
            kern_q <= kernel;
            size_q <= kernel_size;
            err_q  <= 1'b0;
         end else if (load_bad) begin
            err_q  <= 1'b1;
         end
         if (accept) begin
            work_kern_q <= kern_q;
            last_idx_q  <= size_q - SZW'(1);
            win_q       <= win;
            acc_q       <= '0;
         end else if (mac_en) begin
            acc_q <= acc_q + ACC_W'(tap_prod);
         end
      end
   end

   tap_index_counter #(
      .W (SZW)
   ) u_tap_index_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .en       (mac_en),
      .wrap     (last_idx_q),
      .row      (row),
      .col      (col),
      .last_tap (last_tap)
   );

   always_comb begin
      tap_prod = work_kern_q[row][col] * win_q[row][col];
   end

`ifdef CONV_SATURATE_EN
   logic [SUMW-1:0] shifted;
   always_comb begin
      shifted = (SUMW'(acc_q) + ROUND) >> NORM_SHIFT;
      pix_res = (|shifted[SUMW-1:8]) ? 8'hFF : shifted[7:0];
   end
`else
   always_comb begin
      pix_res = 8'((SUMW'(acc_q) + ROUND) >> NORM_SHIFT);
   end
`endif

   always_comb begin
      pix_out = (state_q == ST_OUT) ? pix_res : '0;
      err     = err_q;
   end

endmodule
